// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg
// Shared definitions for the universal shift register: the mode encoding
// and a small helper that classifies a mode as a shift.
package shift_reg_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD = 2'b00;
  localparam mode_t MODE_SHR  = 2'b01;
  localparam mode_t MODE_SHL  = 2'b10;
  localparam mode_t MODE_LOAD = 2'b11;

  // Both shift directions advance the frame counter.
  function automatic logic is_shift(input mode_t m);
    return (m == MODE_SHR) || (m == MODE_SHL);
  endfunction

endpackage

// File: rtl/shift_frame_cnt.sv
// shift_frame_cnt
// Counts shifts within a frame and emits a one-cycle pulse after the
// WIDTH-th shift. The count wraps to 0 on that shift, so back-to-back
// frames pulse every WIDTH shifts.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   inc        a shift is happening on this edge
//   clr        a parallel load is happening on this edge (restarts the frame)
//   frame_done registered pulse, high for the cycle after the last shift
module shift_frame_cnt #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output logic frame_done
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] shift_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_cnt  <= '0;
      frame_done <= 1'b0;
    end else if (clr) begin
      shift_cnt  <= '0;
      frame_done <= 1'b0;
    end else if (inc) begin
      if (shift_cnt == CNT_LAST) begin
        shift_cnt  <= '0;
        frame_done <= 1'b1;
      end else begin
        shift_cnt  <= shift_cnt + CNT_W'(1);
        frame_done <= 1'b0;
      end
    end else begin
      // Holds and disabled cycles keep the count but never extend a pulse.
      frame_done <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_reg_universal.sv
// shift_reg_universal
// Universal shift register with hold, shift-right, shift-left and
// parallel-load modes, a clock enable, serial I/O at both ends and a
// frame-complete pulse. Serves as SIPO/PISO/SISO between serial links
// and word-wide datapaths.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   en         clock enable; all state holds when low
//   mode       00 hold, 01 shift right, 10 shift left, 11 parallel load
//   sdi_r      serial in for right shifts, enters q[WIDTH-1]
//   sdi_l      serial in for left shifts, enters q[0]
//   pdi        parallel load data
//   q          register contents
//   sdo_r      q[0], bit leaving on a right shift
//   sdo_l      q[WIDTH-1], bit leaving on a left shift
//   frame_done one-cycle pulse after the WIDTH-th shift of a frame
module shift_reg_universal
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sdi_r,
  input  logic             sdi_l,
  input  logic [WIDTH-1:0] pdi,
  output logic [WIDTH-1:0] q,
  output logic             sdo_r,
  output logic             sdo_l,
  output logic             frame_done
);

  logic cnt_inc;
  logic cnt_clr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= RESET_VAL;
    end else if (en) begin
      case (mode)
        MODE_SHR:  q <= {sdi_r, q[WIDTH-1:1]};
        MODE_SHL:  q <= {q[WIDTH-2:0], sdi_l};
        MODE_LOAD: q <= pdi;
        default:   q <= q;
      endcase
    end
  end

  // Serial outputs come straight off the register: no extra latency.
  assign sdo_r = q[0];
  assign sdo_l = q[WIDTH-1];

  assign cnt_inc = en && is_shift(mode_t'(mode));
  assign cnt_clr = en && (mode == MODE_LOAD);

  shift_frame_cnt #(
    .WIDTH (WIDTH)
  ) u_frame_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .inc        (cnt_inc),
    .clr        (cnt_clr),
    .frame_done (frame_done)
  );

endmodule

// File: doc/shift_reg_universal.md
Name: shift_reg_universal

Overview:
Parametrised universal shift register, the successor to the fixed single-bit serial-in/serial-out shift register. Provides hold, shift-right, shift-left and parallel-load modes with a clock enable and serial I/O at both ends. Includes a frame counter that pulses when WIDTH shifts have completed since the last load or reset. It sits between serial links and word-wide datapaths as a SIPO/PISO/SISO converter.

Parameters:
WIDTH, 8, register length in bits; must be >= 2.
RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset.

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
en  in  1  clock enable; when 0, all state holds
mode  in  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
sdi_r  in  1  serial input for shift right; enters q[WIDTH-1]
sdi_l  in  1  serial input for shift left; enters q[0]
pdi  in  WIDTH  parallel load data
q  out  WIDTH  register contents (parallel out)
sdo_r  out  1  q[0]; the bit that leaves on a right shift
sdo_l  out  1  q[WIDTH-1]; the bit that leaves on a left shift
frame_done  out  1  one-cycle pulse after the WIDTH-th shift of a frame

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (reset_n). Assertion takes effect immediately; no clock edge is needed.
- Reset values: q=RESET_VAL, internal shift_cnt=0, frame_done=0. sdo_r and sdo_l follow q.
- All state updates occur on the rising edge of clk, and only when en=1.
- mode 01: q <= {sdi_r, q[WIDTH-1:1]}; shift_cnt increments.
- mode 10: q <= {q[WIDTH-2:0], sdi_l}; shift_cnt increments.
- mode 11: q <= pdi; shift_cnt <= 0; frame_done <= 0.
- mode 00 with en=1: q and shift_cnt hold; frame_done <= 0.
- en=0: q and shift_cnt hold regardless of mode; frame_done <= 0.
- shift_cnt width is $clog2(WIDTH). On a shift with shift_cnt==WIDTH-1:
  - shift_cnt wraps to 0.
  - frame_done <= 1 (registered, visible for exactly the following cycle).
- On any other shift, frame_done <= 0. Back-to-back frames therefore give a pulse every WIDTH shifts.
- The counter counts shifts in either direction. Changing direction mid-frame does not clear it; only a load or reset clears it.
- Latency: a bit driven on sdi_r appears on sdo_r after exactly WIDTH right shifts (SISO). It appears in q[WIDTH-1] after 1 shift. The same holds symmetrically for sdi_l/sdo_l.
- sdo_r and sdo_l are pure wires from q, so they are glitch-free registered outputs with no extra latency.
- Reset mid-frame aborts the frame:
  - No frame_done is produced.
  - A pending frame_done is cleared immediately.
- Serial inputs are sampled only on enabled shift edges. pdi is sampled only on enabled load edges.

Decomposition:
- Package shift_reg_pkg holds:
  - localparams MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11;
  - a typedef for the 2-bit mode.
- One natural sub-module, shift_frame_cnt (parameter WIDTH). Ports: clk, reset_n, inc, clr, frame_done. It contains the counter and the pulse register.
- The data path stays in the top module.

Test Plan:
- Reset: hold reset_n=0 with clk running, WIDTH=8 -> q=8'h00, frame_done=0. Release reset off-edge; q is unchanged until the first enabled edge.
- PISO right: load pdi=8'hA5, then 8 right shifts with sdi_r=0 -> sdo_r before each edge reads 1,0,1,0,0,1,0,1; final q=8'h00; frame_done high for exactly the cycle after the 8th shift.
- SISO left: load 8'h00; shift left with sdi_l=1 for one shift, then 0 -> sdo_l=1 after the 8th shift; q=8'h80 at that point; frame_done pulses on the same cycle.
- Enable/hold: after 3 right shifts, set en=0 with mode=01 for 4 cycles, then mode=00 with en=1 for 2 cycles -> q constant. frame_done then appears only after 5 further shifts.
- Reset mid-frame: 4 shifts, then reset_n=0 asynchronously between edges -> q=0 immediately. After release, 8 shifts are needed for the next frame_done.
- Load mid-frame: 7 shifts, then load pdi=8'h3C -> q=8'h3C and no frame_done. Mixed directions (3 right + 5 left) then give frame_done after the 8th shift.
